// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// default data width and the request legality helper.
package lsu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_CAP,
        ST_RD,
        ST_WR,
        RESP
    } lsu_state_t;

    // Illegal width code or misaligned halfword/word address.
    function automatic logic req_bad(input logic we, input logic [2:0] f3,
                                     input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B:  bad = 1'b0;
            F3_H:  bad = lo[0];
            F3_W:  bad = (lo != 2'b00);
            F3_BU: bad = we;
            F3_HU: bad = we | lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline request/response handshake plus the word-wide data-memory bus.
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high; req_ready is high only while the unit is idle,
// and every accepted request ends with exactly one resp_valid pulse
// (unless reset intervenes).
interface lsu_if #(parameter int XLEN = lsu_pkg::XLEN_DEF) ();

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;
    logic            d_r_en;
    logic            d_w_en;
    logic [XLEN-1:0] d_add;
    logic [XLEN-1:0] d_wdata;
    logic [XLEN-1:0] d_rdata;

    // Load/store unit side.
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, d_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               d_r_en, d_w_en, d_add, d_wdata
    );

    // Pipeline plus data memory side.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, d_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               d_r_en, d_w_en, d_add, d_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational byte/halfword lane handling: load extract with sign or zero
// extension, and the read-modify-write merge for sub-word stores.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] mem_word,
    input  logic [1:0]      byte_off,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] st_data,
    output logic [XLEN-1:0] ld_result,
    output logic [XLEN-1:0] st_merged
);

    logic [4:0]      sh;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] ins;

    assign sh      = {byte_off, 3'b000};
    assign shifted = mem_word >> sh;

    // Pick the addressed lane and extend it to full width.
    always_comb begin
        ld_result = '0;
        case (funct3)
            F3_B:  ld_result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_H:  ld_result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_W:  ld_result = mem_word;
            F3_BU: ld_result = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_HU: ld_result = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: ld_result = '0;
        endcase
    end

    // Replace only the addressed lane of the old word; a word store
    // replaces everything.
    always_comb begin
        mask = '1;
        ins  = st_data;
        case (funct3)
            F3_B: begin
                mask = {{(XLEN-8){1'b0}}, 8'hFF} << sh;
                ins  = {{(XLEN-8){1'b0}}, st_data[7:0]} << sh;
            end
            F3_H: begin
                mask = {{(XLEN-16){1'b0}}, 16'hFFFF} << sh;
                ins  = {{(XLEN-16){1'b0}}, st_data[15:0]} << sh;
            end
            default: begin
                mask = '1;
                ins  = st_data;
            end
        endcase
        st_merged = (mem_word & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns RV32I load/store requests into word accesses on a
// word-only data memory with one-cycle registered read.
// Optional macro LSU_BOUNDS_CHECK_EN: word index >= DEPTH takes the error path.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DEPTH = 100,
    parameter int XLEN  = XLEN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    lsu_if.slave       bus,
    output lsu_state_t dbg_state
);

    lsu_state_t      state, state_nxt;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            err_q;
    logic [XLEN-1:0] rdata_q;
    logic            resp_valid_q;
    logic [XLEN-1:0] resp_rdata_q;
    logic            resp_err_q;
    logic [XLEN-1:0] ld_result;
    logic [XLEN-1:0] st_merged;
    logic            accept;
    logic            oob;
    logic            req_err;

`ifdef LSU_BOUNDS_CHECK_EN
    localparam logic [XLEN-3:0] DEPTH_W = (XLEN-2)'(DEPTH);
    assign oob = (bus.req_addr[XLEN-1:2] >= DEPTH_W);
`else
    assign oob = 1'b0;
`endif

    assign accept  = bus.req_valid && (state == IDLE);
    assign req_err = req_bad(bus.req_we, bus.req_funct3, bus.req_addr[1:0]) | oob;

    lsu_align #(.XLEN(XLEN)) u_align (
        .mem_word  (bus.d_rdata),
        .byte_off  (addr_q[1:0]),
        .funct3    (f3_q),
        .st_data   (wdata_q),
        .ld_result (ld_result),
        .st_merged (st_merged)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode; word stores skip the read phase.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                       state_nxt = RESP;
                    else if (!bus.req_we)              state_nxt = LD_RD;
                    else if (bus.req_funct3 == F3_W)   state_nxt = ST_WR;
                    else                               state_nxt = ST_RD;
                end
            end
            LD_RD:   state_nxt = LD_CAP;
            LD_CAP:  state_nxt = RESP;
            ST_RD:   state_nxt = ST_WR;
            ST_WR:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the request on accept; capture the extended load data in LD_CAP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else if (accept) begin
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            err_q   <= req_err;
            rdata_q <= '0;
        end else if (state == LD_CAP) begin
            rdata_q <= ld_result;
        end
    end

    // Registered response: pulse once leaving RESP, hold data until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= (state == RESP);
            if (state == RESP) begin
                resp_rdata_q <= rdata_q;
                resp_err_q   <= err_q;
            end
        end
    end

    // Memory side decodes from state and the latched request only; d_rdata
    // feeds the write data only during ST_WR.
    always_comb begin
        bus.d_r_en  = (state == LD_RD) || (state == ST_RD);
        bus.d_w_en  = (state == ST_WR);
        bus.d_add   = {2'b00, addr_q[XLEN-1:2]};
        bus.d_wdata = '0;
        if (state == ST_WR) bus.d_wdata = st_merged;
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus randomized bench for load_store_unit with a word memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  lsu_state_t dbg_state;

  always #5 clk = ~clk;

  lsu_if #(.XLEN(XLEN)) bus ();

  load_store_unit #(.DEPTH(100), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- memory model ----------------
  // Registered read; data bus carries a poison pattern except in the cycle
  // after a read strobe, so a mistimed sample shows up.
  logic [XLEN-1:0] mem [0:127];
  logic [XLEN-1:0] rd_q = '0;
  logic            rd_vld = 1'b0;

  always @(posedge clk) begin
    rd_vld <= bus.d_r_en;
    if (bus.d_r_en) rd_q <= mem[bus.d_add[6:0]];
    if (bus.d_w_en) mem[bus.d_add[6:0]] <= bus.d_wdata;
  end

  assign bus.d_rdata = rd_vld ? rd_q : 32'hA5A5_5A5A;

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  int r_cnt = 0;
  int w_cnt = 0;
  int resp_cnt = 0;
  logic [31:0] r_add = '0;
  logic [31:0] w_add = '0;
  logic [31:0] w_data = '0;
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.d_r_en || bus.d_w_en) check("strobe_excl", 64'(bus.d_r_en & bus.d_w_en), 64'd0);
      if (bus.d_r_en) begin r_cnt++; r_add = bus.d_add; end
      if (bus.d_w_en) begin w_cnt++; w_add = bus.d_add; w_data = bus.d_wdata; end
      if (bus.resp_valid) begin
        resp_cnt++;
        check("resp_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("resp_err_rdata", 64'({bus.resp_err, bus.resp_rdata}), 64'(e));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input int exp_lat, input int exp_r, input int exp_w);
    int lat;
    lat = -1;
    @(negedge clk);
    check({tag, "_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    exp_q.push_back({exp_err, exp_rd});
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    r_cnt = 0;
    w_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = c - 1;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_rd_strobes"}, 64'(r_cnt), 64'(exp_r));
    check({tag, "_wr_strobes"}, 64'(w_cnt), 64'(exp_w));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  logic [31:0] model [0:63];

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    check("rst_resp_err", 64'(bus.resp_err), 64'd0);
    check("rst_strobes", 64'({bus.d_r_en, bus.d_w_en}), 64'd0);
    check("rst_d_add", 64'(bus.d_add), 64'd0);
    check("rst_d_wdata", 64'(bus.d_wdata), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b1;

    // word store / load
    do_req("sw", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 2, 0, 1);
    check("sw_d_add", 64'(w_add), 64'd4);
    check("sw_d_wdata", 64'(w_data), 64'hDEADBEEF);
    do_req("lw", 1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 3, 1, 0);
    check("lw_d_add", 64'(r_add), 64'd4);

    // sub-word loads with extension
    do_req("sw2", 1'b1, F3_W, 32'h10, 32'h80FF7F01, 1'b0, 32'h0, 2, 0, 1);
    do_req("lb13", 1'b0, F3_B, 32'h13, 32'h0, 1'b0, 32'hFFFFFF80, 3, 1, 0);
    check("lb13_d_add", 64'(r_add), 64'd4);
    repeat (2) @(negedge clk);
    check("lb13_hold", 64'(bus.resp_rdata), 64'hFFFFFF80);
    do_req("lbu13", 1'b0, F3_BU, 32'h13, 32'h0, 1'b0, 32'h00000080, 3, 1, 0);
    do_req("lb11", 1'b0, F3_B, 32'h11, 32'h0, 1'b0, 32'h0000007F, 3, 1, 0);
    do_req("lb10", 1'b0, F3_B, 32'h10, 32'h0, 1'b0, 32'h00000001, 3, 1, 0);
    do_req("lh12", 1'b0, F3_H, 32'h12, 32'h0, 1'b0, 32'hFFFF80FF, 3, 1, 0);
    do_req("lhu12", 1'b0, F3_HU, 32'h12, 32'h0, 1'b0, 32'h000080FF, 3, 1, 0);
    do_req("lh10", 1'b0, F3_H, 32'h10, 32'h0, 1'b0, 32'h00007F01, 3, 1, 0);

    // read-modify-write stores
    do_req("sw3", 1'b1, F3_W, 32'h10, 32'h11223344, 1'b0, 32'h0, 2, 0, 1);
    do_req("sb11", 1'b1, F3_B, 32'h11, 32'h000000AA, 1'b0, 32'h0, 3, 1, 1);
    check("sb11_d_wdata", 64'(w_data), 64'h1122AA44);
    check("sb11_r_add", 64'(r_add), 64'd4);
    check("sb11_w_add", 64'(w_add), 64'd4);
    do_req("sh12", 1'b1, F3_H, 32'h12, 32'h5555BEEF, 1'b0, 32'h0, 3, 1, 1);
    check("sh12_d_wdata", 64'(w_data), 64'hBEEFAA44);
    do_req("lw_rmw", 1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'hBEEFAA44, 3, 1, 0);

    // randomized word/byte/half traffic against a shadow model
    for (int i = 0; i < 8; i++) begin
      int idx;
      int off;
      int hoff;
      logic [31:0] d;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] e;
      idx  = $urandom_range(8, 63);
      off  = $urandom_range(0, 3);
      hoff = 2 * $urandom_range(0, 1);
      d    = $urandom;
      b    = 8'($urandom);
      do_req("rnd_sw", 1'b1, F3_W, 32'(idx) << 2, d, 1'b0, 32'h0, 2, 0, 1);
      model[idx] = d;
      do_req("rnd_sb", 1'b1, F3_B, (32'(idx) << 2) | 32'(off), {24'h0, b}, 1'b0, 32'h0, 3, 1, 1);
      e = model[idx];
      e[off*8 +: 8] = b;
      model[idx] = e;
      check("rnd_sb_wdata", 64'(w_data), 64'(e));
      h = e[hoff*8 +: 16];
      do_req("rnd_lh", 1'b0, F3_H, (32'(idx) << 2) | 32'(hoff), 32'h0, 1'b0,
             {{16{h[15]}}, h}, 3, 1, 0);
      do_req("rnd_lw", 1'b0, F3_W, 32'(idx) << 2, 32'h0, 1'b0, model[idx], 3, 1, 0);
    end

    // error paths: no strobes, response one cycle later
    do_req("lw_mis", 1'b0, F3_W, 32'h02, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    do_req("sh_mis", 1'b1, F3_H, 32'h05, 32'h1234, 1'b1, 32'h0, 1, 0, 0);
    do_req("lh_mis", 1'b0, F3_H, 32'h13, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    do_req("f3_011", 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    do_req("f3_110", 1'b0, 3'b110, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    do_req("f3_111", 1'b1, 3'b111, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    do_req("st_bu", 1'b1, F3_BU, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    do_req("st_hu", 1'b1, F3_HU, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    do_req("lw_after_err", 1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'hBEEFAA44, 3, 1, 0);

    // bounds
`ifdef LSU_BOUNDS_CHECK_EN
    do_req("lw_oob", 1'b0, F3_W, 32'h190, 32'h0, 1'b1, 32'h0, 1, 0, 0);
    do_req("sw_oob", 1'b1, F3_W, 32'h190, 32'h12345678, 1'b1, 32'h0, 1, 0, 0);
    do_req("lw_last", 1'b0, F3_W, 32'h18C, 32'h0, 1'b0, mem[99], 3, 1, 0);
`else
    do_req("sw_100", 1'b1, F3_W, 32'h190, 32'h12345678, 1'b0, 32'h0, 2, 0, 1);
    check("sw_100_d_add", 64'(w_add), 64'd100);
    do_req("lw_100", 1'b0, F3_W, 32'h190, 32'h0, 1'b0, 32'h12345678, 3, 1, 0);
    check("lw_100_d_add", 64'(r_add), 64'd100);
`endif

    // reset in the middle of LD_RD: strobe drops at once, no response
    begin
      int resp_before;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_funct3 = F3_W;
      bus.req_addr   = 32'h10;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      check("mid_rd_strobe", 64'(bus.d_r_en), 64'd1);
      resp_before = resp_cnt;
      #2;
      rst = 1'b0;
      #1;
      check("mid_rst_strobes", 64'({bus.d_r_en, bus.d_w_en}), 64'd0);
      check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 64'(bus.req_ready), 64'd1);
      check("post_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      repeat (5) @(negedge clk);
      check("post_rst_no_resp", 64'(resp_cnt), 64'(resp_before));
    end
    do_req("lw_recover", 1'b0, F3_W, 32'h10, 32'h0, 1'b0, 32'hBEEFAA44, 3, 1, 0);

    repeat (2) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
